// File: rtl/lfsr_noise_gen.sv
// Prescaled Galois LFSR noise source with zero-state lock-up guard.
// Define LFSR_STEP_EN to add the synchronised manual single-step input.
module lfsr_noise_gen #(
  parameter int unsigned WIDTH = 32,
  parameter logic [31:0] TAPS  = 32'h80200003,
  parameter logic [31:0] SEED  = 32'h00000001,
  parameter int unsigned DIV   = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
`ifdef LFSR_STEP_EN
  input  logic             step,
`endif
  output logic [31:0]      lfsr_val,
  output logic             lfsr_bit,
  output logic             tick
);

  localparam int unsigned      CNT_W    = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DIV - 1);
  localparam logic [WIDTH-1:0] SEED_W   = SEED[WIDTH-1:0];
  localparam logic [WIDTH-1:0] TAPS_W   = TAPS[WIDTH-1:0];

  function automatic logic [WIDTH-1:0] galois_next(input logic [WIDTH-1:0] s);
    return s[0] ? ((s >> 1) ^ TAPS_W) : (s >> 1);
  endfunction

  logic [CNT_W-1:0] cnt_p0;
  logic [WIDTH-1:0] state_p0;
  logic             term;
  logic             step_rise;

  assign term = enable && (cnt_p0 == CNT_TERM);

`ifdef LFSR_STEP_EN
  // Two synchroniser flops plus one history flop for rising-edge detection.
  logic [2:0] step_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) step_sync <= '0;
    else       step_sync <= {step_sync[1:0], step};
  end

  assign step_rise = step_sync[1] & ~step_sync[2];
`else
  assign step_rise = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       cnt_p0 <= '0;
    else if (load)   cnt_p0 <= '0;
    else if (enable) cnt_p0 <= term ? '0 : cnt_p0 + CNT_W'(1);
  end

  // Load beats the zero-state guard, which beats any advance; only advances tick.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_p0 <= SEED_W;
      tick     <= 1'b0;
    end else begin
      tick <= 1'b0;
      if (load) begin
        state_p0 <= (seed == '0) ? SEED_W : seed;
      end else if (state_p0 == '0) begin
        state_p0 <= SEED_W;
      end else if (term || step_rise) begin
        state_p0 <= galois_next(state_p0);
        tick     <= 1'b1;
      end
    end
  end

  always_comb begin
    lfsr_val              = '0;
    lfsr_val[WIDTH-1:0]   = state_p0;
  end

  assign lfsr_bit = state_p0[0];

endmodule
